// File: rtl/filter_pkg.sv
// Shared types and the window-code decode for the deglitch filter bank.
package filter_pkg;

  typedef enum logic [1:0] {
    FT_BYPASS = 2'b00,
    FT_RISE   = 2'b01,
    FT_FALL   = 2'b10,
    FT_BOTH   = 2'b11
  } filter_type_e;

  localparam int WIN_CODE_W = 4;

  // Window code to counter load value, clipped to what a cnt_w-bit counter can hold.
  function automatic int unsigned win_load(input logic [WIN_CODE_W-1:0] code,
                                           input int unsigned cnt_w);
    int unsigned l;
    int unsigned lmax;
    case (code)
      4'd0:    l = 3;
      4'd1:    l = 7;
      4'd2:    l = 15;
      4'd3:    l = 31;
      4'd4:    l = 47;
      4'd5:    l = 63;
      4'd6:    l = 127;
      4'd7:    l = 255;
      4'd8:    l = 511;
      4'd9:    l = 639;
      4'd10:   l = 767;
      4'd11:   l = 895;
      4'd12:   l = 1023;
      4'd13:   l = 1279;
      4'd14:   l = 1535;
      default: l = 2047;
    endcase
    lmax = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
    return (l > lmax) ? lmax : l;
  endfunction

endpackage

// File: rtl/filter_channel.sv
// One deglitch channel: input delay reg, window counter, output reg and sticky status.
module filter_channel
  import filter_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [1:0]            i_type,
  input  logic [WIN_CODE_W-1:0] i_win,
  input  logic                  i_clr,
  input  logic                  i_din,
  output logic                  o_out,
  output logic                  o_status
);

  filter_type_e     w_type;
  filter_type_e     r_type_d;
  logic             r_din_d;
  logic             r_out;
  logic             r_status;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_load;
  logic             w_out_nxt;
  logic             w_set;
  logic             w_busy;
  logic             w_expire;

  assign w_type   = filter_type_e'(i_type);
  assign w_load   = CNT_W'(win_load(i_win, CNT_W));
  assign w_busy   = (r_cnt != '0);
  assign w_expire = (r_cnt == CNT_W'(1));

  // Priority: mode change > abort/force > edge load > decrement.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_out_nxt = r_out;
    w_set     = 1'b0;
    if (w_type != r_type_d) begin
      w_cnt_nxt = '0;
      if (w_type == FT_BYPASS) w_out_nxt = i_din;
    end else begin
      case (w_type)
        FT_BYPASS: begin
          w_cnt_nxt = '0;
          w_out_nxt = i_din;
        end
        FT_RISE: begin
          if (!i_din) begin
            w_cnt_nxt = '0;
            w_out_nxt = 1'b0;
          end else if (!r_din_d) begin
            w_cnt_nxt = w_load;
          end else if (w_busy) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (w_expire) begin
              w_out_nxt = 1'b1;
              w_set     = ~r_out;
            end
          end
        end
        FT_FALL: begin
          if (i_din) begin
            w_cnt_nxt = '0;
            w_out_nxt = 1'b1;
          end else if (r_din_d) begin
            w_cnt_nxt = w_load;
          end else if (w_busy) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (w_expire) begin
              w_out_nxt = 1'b0;
              w_set     = r_out;
            end
          end
        end
        FT_BOTH: begin
          if (i_din == r_out) begin
            w_cnt_nxt = '0;
          end else if (i_din != r_din_d) begin
            w_cnt_nxt = w_load;
          end else if (w_busy) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (w_expire) begin
              w_out_nxt = i_din;
              w_set     = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_type_d <= FT_BYPASS;
      r_din_d  <= 1'b0;
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_type_d <= w_type;
      r_din_d  <= i_din;
      r_cnt    <= w_cnt_nxt;
      r_out    <= w_out_nxt;
      // A set in the same cycle as a clear strobe wins.
      r_status <= w_set | (r_status & ~i_clr);
    end
  end

  assign o_out    = r_out;
  assign o_status = r_status;

endmodule

// File: rtl/filter_bank.sv
// Multi-channel deglitch filter bank with sticky W1C status and a registered irq.
// Define FILTER_BANK_SYNC_EN to put a 2-flop synchroniser in front of every input.
module filter_bank
  import filter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 11
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [2*NUM_CH-1:0]          filter_type_i,
  input  logic [WIN_CODE_W*NUM_CH-1:0] window_size_i,
  input  logic [NUM_CH-1:0]            int_en_i,
  input  logic [NUM_CH-1:0]            int_clr_i,
  input  logic [NUM_CH-1:0]            data_in_i,
  output logic [NUM_CH-1:0]            data_out_o,
  output logic [NUM_CH-1:0]            int_status_o,
  output logic                         irq_o
);

  logic [NUM_CH-1:0][1:0]            w_type;
  logic [NUM_CH-1:0][WIN_CODE_W-1:0] w_win;
  logic [NUM_CH-1:0]                 w_din;
  logic [NUM_CH-1:0]                 w_status;
  logic                              r_irq;

  assign w_type = filter_type_i;
  assign w_win  = window_size_i;

`ifdef FILTER_BANK_SYNC_EN
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= data_in_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_din = r_sync2;
`else
  assign w_din = data_in_i;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    filter_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .i_type   (w_type[c]),
      .i_win    (w_win[c]),
      .i_clr    (int_clr_i[c]),
      .i_din    (w_din[c]),
      .o_out    (data_out_o[c]),
      .o_status (w_status[c])
    );
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_irq <= 1'b0;
    else         r_irq <= |(w_status & int_en_i);
  end

  assign int_status_o = w_status;
  assign irq_o        = r_irq;

endmodule

// File: tb/tb_filter_bank.sv
// Bench for filter_bank: directed table + sequences, then random traffic vs a run-length model.
module tb_filter_bank;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 11;
`ifdef FILTER_BANK_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic                clk = 1'b0;
  logic                rstn;
  logic [2*NUM_CH-1:0] ftype;
  logic [4*NUM_CH-1:0] wsize;
  logic [NUM_CH-1:0]   en, clr, din;
  logic [NUM_CH-1:0]   dout, stat;
  logic                irq;

  always #5 clk = ~clk;

  filter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rstn_i(rstn), .filter_type_i(ftype), .window_size_i(wsize),
    .int_en_i(en), .int_clr_i(clr), .data_in_i(din),
    .data_out_o(dout), .int_status_o(stat), .irq_o(irq)
  );

  int checks = 0;
  int failures = 0;

  // Model: per channel, count samples since the qualifying edge; toggle when the run reaches L+1.
  int     LOADS [16] = '{3, 7, 15, 31, 47, 63, 127, 255, 511, 639, 767, 895, 1023, 1279, 1535, 2047};
  int     m_run [NUM_CH];
  int     m_L   [NUM_CH];
  bit     m_out [NUM_CH];
  bit     m_prev[NUM_CH];
  bit     m_stat[NUM_CH];
  bit     m_s1  [NUM_CH];
  bit     m_s2  [NUM_CH];
  bit [1:0] m_ptype[NUM_CH];
  bit     m_irq;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_L[c] = 0; m_out[c] = 0; m_prev[c] = 0;
      m_stat[c] = 0; m_s1[c] = 0; m_s2[c] = 0; m_ptype[c] = 0;
    end
    m_irq = 0;
  endtask

  task automatic model_step();
    bit irq_n = 0;
    for (int c = 0; c < NUM_CH; c++) irq_n |= m_stat[c] & en[c];
    m_irq = irq_n;
    for (int c = 0; c < NUM_CH; c++) begin
      bit [1:0] ty = ftype[2*c +: 2];
      bit d, set, frc, edg;
      int lmax = (1 << CNT_W) - 1;
      if (SYNC_LAT > 0) begin
        d = m_s2[c]; m_s2[c] = m_s1[c]; m_s1[c] = din[c];
      end else d = din[c];
      set = 0;
      if (ty != m_ptype[c]) begin
        m_run[c] = 0;
        if (ty == 2'b00) m_out[c] = d;
      end else if (ty == 2'b00) begin
        m_run[c] = 0; m_out[c] = d;
      end else begin
        case (ty)
          2'b01:   begin frc = !d;          edg = d && !m_prev[c]; end
          2'b10:   begin frc = d;           edg = !d && m_prev[c]; end
          default: begin frc = (d == m_out[c]); edg = (d != m_prev[c]); end
        endcase
        if (frc) begin
          m_run[c] = 0;
          if (ty != 2'b11) m_out[c] = d;
        end else if (edg) begin
          m_run[c] = 1;
          m_L[c] = (LOADS[wsize[4*c +: 4]] > lmax) ? lmax : LOADS[wsize[4*c +: 4]];
        end else if (m_run[c] > 0) begin
          m_run[c]++;
          if (m_run[c] == m_L[c] + 1) begin
            set = (m_out[c] != d); m_out[c] = d; m_run[c] = 0;
          end
        end
      end
      m_stat[c]  = set | (m_stat[c] & !clr[c]);
      m_prev[c]  = d;
      m_ptype[c] = ty;
    end
  endtask

  task automatic tick();
    logic [NUM_CH-1:0] eo, es;
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin eo[c] = m_out[c]; es[c] = m_stat[c]; end
    chk("model_dout", 32'(dout), 32'(eo));
    chk("model_stat", 32'(stat), 32'(es));
    chk("model_irq",  32'(irq),  32'(m_irq));
  endtask

  typedef struct { bit d; bit out; bit st; bit irq; } vec_t;
  vec_t tbl[12];
  bit   hist[$];

  initial begin
    tbl[0] = '{1,0,0,0}; tbl[1] = '{1,0,0,0}; tbl[2] = '{1,0,0,0}; tbl[3] = '{1,1,1,0};
    for (int k = 4; k < 10; k++) tbl[k] = '{1,1,1,1};
    tbl[10] = '{0,0,1,1}; tbl[11] = '{0,0,1,1};

    rstn = 0; ftype = 8'b00_00_00_01; wsize = '0; en = 4'b0001; clr = '0; din = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_dout", 32'(dout), 0);
    chk("reset_stat", 32'(stat), 0);
    chk("reset_irq",  32'(irq),  0);
    rstn = 1;
    repeat (3) tick();

    // 1: rise, L=3, table driven
    for (int k = 0; k < 12 + SYNC_LAT; k++) begin
      din[0] = tbl[(k < 12) ? k : 11].d;
      tick();
      if (k >= SYNC_LAT) begin
        chk("t1_out",  32'(dout[0]), 32'(tbl[k-SYNC_LAT].out));
        chk("t1_stat", 32'(stat[0]), 32'(tbl[k-SYNC_LAT].st));
        chk("t1_irq",  32'(irq),     32'(tbl[k-SYNC_LAT].irq));
      end
    end

    // 2: rise, L=7, 5-cycle pulse is swallowed
    clr = 4'b0001; tick(); clr = '0;
    wsize[3:0] = 4'd1;
    din[0] = 1; repeat (5) tick();
    din[0] = 0;
    for (int k = 0; k < 6 + SYNC_LAT; k++) begin
      tick();
      chk("t2_out", 32'(dout[0]), 0);
      chk("t2_stat", 32'(stat[0]), 0);
    end

    // 3: both, abort at count==2 then a clean toggle
    ftype[1:0] = 2'b11; wsize[3:0] = 4'd0;
    repeat (2 + SYNC_LAT) tick();
    din[0] = 1; tick(); tick();
    din[0] = 0; tick();
    din[0] = 1;
    repeat (3 + SYNC_LAT) tick();
    chk("t3_abort_out", 32'(dout[0]), 0);
    tick();
    chk("t3_toggle_out", 32'(dout[0]), 1);
    chk("t3_toggle_stat", 32'(stat[0]), 1);

    // 4: set beats clear, then clear alone, irq follows a cycle later
    clr = '1; tick(); clr = '0;
    en = 4'b0010; ftype[3:2] = 2'b01; wsize[7:4] = 4'd0;
    repeat (2) tick();
    din[1] = 1; repeat (3 + SYNC_LAT) tick();
    clr[1] = 1; tick();
    chk("t4_set_wins", 32'(stat[1]), 1);
    tick();
    chk("t4_cleared", 32'(stat[1]), 0);
    chk("t4_irq_hold", 32'(irq), 1);
    clr[1] = 0; tick();
    chk("t4_irq_drop", 32'(irq), 0);

    // 5: ch2 rise -> bypass mid-count
    ftype[5:4] = 2'b01; wsize[11:8] = 4'd2; tick();
    din[2] = 1; repeat (4) tick();
    ftype[5:4] = 2'b00;
    hist.delete();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) din[2] = 1'($urandom_range(0, 1));
      hist.push_back(din[2]);
      tick();
      if (k >= SYNC_LAT + 1) chk("t5_bypass_out", 32'(dout[2]), 32'(hist[hist.size()-1-SYNC_LAT]));
      chk("t5_stat", 32'(stat[2]), 0);
    end

    // 6: async reset mid-count on all channels (fall mode keeps outputs high while counting)
    ftype = 8'b10_10_10_10; wsize = {4{4'd5}}; en = '1;
    din = '1; repeat (3 + SYNC_LAT) tick();
    din = '0; repeat (5) tick();
    chk("t6_pre_reset", 32'(dout), 32'hF);
    #3 rstn = 0;
    #1;
    chk("t6_rst_dout", 32'(dout), 0);
    chk("t6_rst_stat", 32'(stat), 0);
    chk("t6_rst_irq",  32'(irq),  0);
    model_reset();
    @(posedge clk); #1; rstn = 1;

    // random traffic
    wsize = '0; clr = '0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        int c = $urandom_range(0, NUM_CH-1);
        ftype[2*c +: 2] = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 15) == 0) begin
        int c = $urandom_range(0, NUM_CH-1);
        wsize[4*c +: 4] = 4'($urandom_range(0, 2));
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 5) == 0) din[c] = ~din[c];
        clr[c] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 31) == 0) en = 4'($urandom_range(0, 15));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
